// File: rtl/srf_write_arbiter.sv
// Purpose: round-robin share of the SRF write port among NUM_REQ producers, plus per-stream pending-write scoreboard.
// Latency: handshake in cycle N gives the registered SRF write in cycle N+1; full throughput back-to-back.
// Backpressure: none beyond losing arbitration; req_ready is a combinational one-hot grant to the winner.
module srf_write_arbiter #(
   parameter int NUM_REQ             = 3,
   parameter int NUM_STREAM_ID       = 5,
   parameter int MIN_VEC_LENGTH      = 16,
   parameter int NUM_TILES_PER_SLICE = 20,
   localparam int SRC_W              = $clog2(NUM_REQ),
   localparam int NUM_STREAMS        = 2**NUM_STREAM_ID
) (
   input  logic                                                  clk,
   input  logic                                                  rst,
   input  logic [NUM_REQ-1:0]                                    req_valid,
   output logic [NUM_REQ-1:0]                                    req_ready,
   input  logic [NUM_REQ*NUM_STREAM_ID-1:0]                      req_stream_id,
   input  logic [NUM_REQ*NUM_TILES_PER_SLICE*MIN_VEC_LENGTH-1:0] req_data,
   output logic                                                  srf_write_enable,
   output logic [NUM_STREAM_ID-1:0]                              srf_write_stream,
   output logic [MIN_VEC_LENGTH-1:0]                             srf_write_data [0:NUM_TILES_PER_SLICE-1],
   output logic [SRC_W-1:0]                                      srf_write_src,
   input  logic                                                  reserve_valid,
   input  logic [NUM_STREAM_ID-1:0]                              reserve_stream_id,
   output logic [NUM_STREAMS-1:0]                                stream_busy,
   output logic                                                  reserve_error,
   output logic                                                  unreserved_write
);

   // Requester count at the width of the pointer sum, so the modulo wrap compares like widths.
   localparam logic [SRC_W:0] NREQ = (SRC_W+1)'(NUM_REQ);

   logic [SRC_W-1:0]          rr_ptr;
   logic [SRC_W-1:0]          winner;
   logic [SRC_W-1:0]          cand;
   logic [SRC_W:0]            sum;
   logic                      found;
   logic [NUM_STREAM_ID-1:0]  sel_stream;
   logic [MIN_VEC_LENGTH-1:0] sel_data [0:NUM_TILES_PER_SLICE-1];
   logic [NUM_STREAMS-1:0]    busy_nxt;
   logic                      err_nxt;

   // Round-robin scan from rr_ptr; the wrap is explicit so non-power-of-2 NUM_REQ never relies on overflow.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      cand   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
         if (sum >= NREQ) begin
            sum = sum - NREQ;
         end
         cand = sum[SRC_W-1:0];
         if (!found && req_valid[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign req_ready = found ? (NUM_REQ'(1) << winner) : '0;

   // Select the winning requester's stream id and vector from the flattened input buses.
   always_comb begin
      sel_stream = '0;
      for (int e = 0; e < NUM_TILES_PER_SLICE; e++) begin
         sel_data[e] = '0;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == SRC_W'(i)) begin
            sel_stream = req_stream_id[i*NUM_STREAM_ID +: NUM_STREAM_ID];
            for (int e = 0; e < NUM_TILES_PER_SLICE; e++) begin
               sel_data[e] = req_data[(i*NUM_TILES_PER_SLICE+e)*MIN_VEC_LENGTH +: MIN_VEC_LENGTH];
            end
         end
      end
   end

   // Register the granted write and advance the pointer past the winner; data holds when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         srf_write_enable <= 1'b0;
         srf_write_stream <= '0;
         srf_write_src    <= '0;
         rr_ptr           <= '0;
         for (int e = 0; e < NUM_TILES_PER_SLICE; e++) begin
            srf_write_data[e] <= '0;
         end
      end else begin
         srf_write_enable <= found;
         if (found) begin
            srf_write_stream <= sel_stream;
            srf_write_src    <= winner;
            for (int e = 0; e < NUM_TILES_PER_SLICE; e++) begin
               srf_write_data[e] <= sel_data[e];
            end
            if (winner == SRC_W'(NUM_REQ-1)) begin
               rr_ptr <= '0;
            end else begin
               rr_ptr <= winner + SRC_W'(1);
            end
         end
      end
   end

   // Scoreboard next state: commit clears, a same-cycle reserve to that stream wins and re-sets it.
   always_comb begin
      busy_nxt = stream_busy;
      if (srf_write_enable) begin
         busy_nxt[srf_write_stream] = 1'b0;
      end
      if (reserve_valid) begin
         busy_nxt[reserve_stream_id] = 1'b1;
      end
      err_nxt = reserve_valid && stream_busy[reserve_stream_id] &&
                !(srf_write_enable && (srf_write_stream == reserve_stream_id));
   end

   // Scoreboard and reserve-collision flag registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stream_busy   <= '0;
         reserve_error <= 1'b0;
      end else begin
         stream_busy   <= busy_nxt;
         reserve_error <= err_nxt;
      end
   end

   assign unreserved_write = srf_write_enable && !stream_busy[srf_write_stream];

endmodule

// File: tb/tb_srf_write_arbiter.sv
// Directed bench for srf_write_arbiter: stimulus pushes expected SRF writes into a queue,
// a negedge monitor pops and compares every write the DUT emits; scoreboard/grant checks inline.
module tb_srf_write_arbiter;

   localparam int NR = 3;
   localparam int NS = 5;
   localparam int VL = 16;
   localparam int NT = 20;

   logic              clk;
   logic              rst;
   logic [NR-1:0]     req_valid;
   logic [NR-1:0]     req_ready;
   logic [NR*NS-1:0]  req_stream_id;
   logic [NR*NT*VL-1:0] req_data;
   logic              srf_write_enable;
   logic [NS-1:0]     srf_write_stream;
   logic [VL-1:0]     srf_write_data [0:NT-1];
   logic [1:0]        srf_write_src;
   logic              reserve_valid;
   logic [NS-1:0]     reserve_stream_id;
   logic [31:0]       stream_busy;
   logic              reserve_error;
   logic              unreserved_write;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [NS-1:0] stream;
      logic [VL-1:0] base;
      logic [1:0]    src;
      logic          unrsv;
   } exp_t;

   exp_t exp_q[$];

   srf_write_arbiter #(
      .NUM_REQ(NR), .NUM_STREAM_ID(NS), .MIN_VEC_LENGTH(VL), .NUM_TILES_PER_SLICE(NT)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_stream_id(req_stream_id), .req_data(req_data),
      .srf_write_enable(srf_write_enable), .srf_write_stream(srf_write_stream),
      .srf_write_data(srf_write_data), .srf_write_src(srf_write_src),
      .reserve_valid(reserve_valid), .reserve_stream_id(reserve_stream_id),
      .stream_busy(stream_busy), .reserve_error(reserve_error),
      .unreserved_write(unreserved_write)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input int stream, input logic [VL-1:0] base);
      req_stream_id[i*NS +: NS] = NS'(stream);
      for (int e = 0; e < NT; e++) begin
         req_data[(i*NT+e)*VL +: VL] = base + VL'(e);
      end
   endtask

   task automatic push(input int stream, input logic [VL-1:0] base, input int src, input logic unrsv);
      exp_t x;
      x.stream = NS'(stream);
      x.base   = base;
      x.src    = 2'(src);
      x.unrsv  = unrsv;
      exp_q.push_back(x);
   endtask

   // Monitor: every committed write must match the oldest expected write.
   initial begin
      exp_t x;
      int   bi;
      int   idx;
      forever begin
         @(negedge clk);
         if (!rst && srf_write_enable) begin
            chk("write_expected", {31'd0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
               x = exp_q.pop_front();
               chk("wr_stream", srf_write_stream, x.stream);
               chk("wr_src", srf_write_src, x.src);
               chk("wr_unreserved", unreserved_write, x.unrsv);
               bi = -1;
               for (int e = 0; e < NT; e++) begin
                  if (bi < 0 && srf_write_data[e] !== x.base + VL'(e)) bi = e;
               end
               idx = (bi < 0) ? 0 : bi;
               chk("wr_data", srf_write_data[idx], x.base + VL'(idx));
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish checks=%0d errors=%0d", checks, errors);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      req_valid = '0;
      req_stream_id = '0;
      req_data = '0;
      reserve_valid = 1'b0;
      reserve_stream_id = '0;

      // 1: reset for 3 cycles, then idle
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_enable", srf_write_enable, 0);
      chk("rst_stream", srf_write_stream, 0);
      chk("rst_src", srf_write_src, 0);
      chk("rst_data0", srf_write_data[0], 0);
      chk("rst_data19", srf_write_data[NT-1], 0);
      chk("rst_busy", stream_busy, 0);
      chk("rst_rerr", reserve_error, 0);
      chk("rst_unrsv", unreserved_write, 0);
      step();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("idle_enable", srf_write_enable, 0);
         chk("idle_ready", req_ready, 0);
         step();
      end

      // 2: reserve stream 7, single write from requester 1
      reserve_valid = 1'b1;
      reserve_stream_id = 5'd7;
      step();
      reserve_valid = 1'b0;
      set_req(1, 7, 16'd1);
      req_valid = 3'b010;
      push(7, 16'd1, 1, 1'b0);
      @(negedge clk);
      chk("t2_ready", req_ready, 3'b010);
      chk("t2_busy_set", stream_busy[7], 1);
      step();
      req_valid = '0;
      @(negedge clk);
      chk("t2_enable", srf_write_enable, 1);
      chk("t2_busy_commit", stream_busy[7], 1);
      step();
      @(negedge clk);
      chk("t2_busy_clr", stream_busy[7], 0);
      chk("t2_enable_off", srf_write_enable, 0);

      // lone requester 2 to unreserved stream 2; also brings the pointer back to 0
      step();
      set_req(2, 2, 16'h0200);
      req_valid = 3'b100;
      push(2, 16'h0200, 2, 1'b1);
      @(negedge clk);
      chk("lone2_ready", req_ready, 3'b100);
      step();
      req_valid = '0;
      @(negedge clk);

      // 3: all three valid for 6 cycles -> grants 0,1,2,0,1,2
      set_req(0, 10, 16'h1000);
      set_req(1, 11, 16'h2000);
      set_req(2, 12, 16'h3000);
      for (int k = 0; k < 6; k++) begin
         step();
         req_valid = 3'b111;
         push(10 + (k % 3), 16'h1000 * 16'((k % 3) + 1), k % 3, 1'b1);
         @(negedge clk);
         chk("rr_ready", req_ready, 32'd1 << (k % 3));
         if (k > 0) chk("rr_enable", srf_write_enable, 1);
      end
      step();
      req_valid = '0;
      @(negedge clk);
      chk("rr_enable_last", srf_write_enable, 1);
      step();
      @(negedge clk);
      chk("rr_enable_off", srf_write_enable, 0);

      // 4: reserve stream 3 twice in a row
      step();
      reserve_valid = 1'b1;
      reserve_stream_id = 5'd3;
      @(negedge clk);
      chk("t4_rerr_a", reserve_error, 0);
      step();
      @(negedge clk);
      chk("t4_busy_a", stream_busy[3], 1);
      chk("t4_rerr_b", reserve_error, 0);
      step();
      reserve_valid = 1'b0;
      @(negedge clk);
      chk("t4_rerr_pulse", reserve_error, 1);
      chk("t4_busy_b", stream_busy[3], 1);
      step();
      @(negedge clk);
      chk("t4_rerr_drop", reserve_error, 0);
      chk("t4_busy_c", stream_busy[3], 1);

      // 5: reserve stream 5, write it, re-reserve in the commit cycle, then write again
      step();
      reserve_valid = 1'b1;
      reserve_stream_id = 5'd5;
      step();
      reserve_valid = 1'b0;
      set_req(0, 5, 16'h0500);
      req_valid = 3'b001;
      push(5, 16'h0500, 0, 1'b0);
      @(negedge clk);
      chk("t5_ready_a", req_ready, 3'b001);
      step();
      req_valid = '0;
      reserve_valid = 1'b1;
      reserve_stream_id = 5'd5;
      @(negedge clk);
      chk("t5_commit_enable", srf_write_enable, 1);
      step();
      reserve_valid = 1'b0;
      set_req(1, 5, 16'h0600);
      req_valid = 3'b010;
      push(5, 16'h0600, 1, 1'b0);
      @(negedge clk);
      chk("t5_busy_kept", stream_busy[5], 1);
      chk("t5_no_rerr", reserve_error, 0);
      chk("t5_ready_b", req_ready, 3'b010);
      step();
      req_valid = '0;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("t5_busy_clr", stream_busy[5], 0);

      // 6: async reset mid-write; pointer must restart at 0
      step();
      reserve_valid = 1'b1;
      reserve_stream_id = 5'd20;
      step();
      reserve_valid = 1'b0;
      set_req(0, 9, 16'h0300);
      req_valid = 3'b001;
      push(9, 16'h0300, 0, 1'b1);
      @(negedge clk);
      chk("t6_ready", req_ready, 3'b001);
      chk("t6_busy_pre", stream_busy[20], 1);
      step();
      @(negedge clk);
      chk("t6_enable_pre", srf_write_enable, 1);
      #2;
      rst = 1'b1;
      req_valid = '0;
      #1;
      chk("t6_enable_async", srf_write_enable, 0);
      chk("t6_busy_async", stream_busy, 0);
      step();
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_no_write_after_release", srf_write_enable, 0);
      step();
      set_req(1, 11, 16'h0400);
      req_valid = 3'b011;
      push(9, 16'h0300, 0, 1'b1);
      @(negedge clk);
      chk("t6_first_grant", req_ready, 3'b001);
      step();
      req_valid = '0;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("t6_enable_off", srf_write_enable, 0);

      repeat (3) step();
      chk("queue_drained", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/srf_write_arbiter.md
Name: srf_write_arbiter

Overview:
- Shares the single streaming register file (SRF) write port among NUM_REQ producers: port 0 is the memory unit load path, port 1 is the VXM result path, and port 2 is spare.
- Uses a round-robin grant.
- Registers the winning vector into the SRF write port one cycle after the handshake.
- Keeps a per-stream scoreboard of pending destination writes. The ICU dispatcher reserves an entry at issue and polls it to stall read-after-write hazards.

Parameters:
NUM_REQ, 3, number of write requesters (2..8)
NUM_STREAM_ID, 5, stream-id width; 2**NUM_STREAM_ID streams
MIN_VEC_LENGTH, 16, element width in bits
NUM_TILES_PER_SLICE, 20, elements per vector

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  request valid, one bit per requester
req_ready  output  NUM_REQ  grant/accept, one bit per requester, combinational
req_stream_id  input  NUM_REQ*NUM_STREAM_ID  destination stream; requester i occupies bits [i*NUM_STREAM_ID +: NUM_STREAM_ID]
req_data  input  NUM_REQ*NUM_TILES_PER_SLICE*MIN_VEC_LENGTH  flattened vectors; element e of requester i at [(i*NUM_TILES_PER_SLICE+e)*MIN_VEC_LENGTH +: MIN_VEC_LENGTH]
srf_write_enable  output  1  registered SRF write strobe
srf_write_stream  output  NUM_STREAM_ID  registered write stream id
srf_write_data  output  MIN_VEC_LENGTH x [0:NUM_TILES_PER_SLICE-1]  registered write vector (unpacked array)
srf_write_src  output  $clog2(NUM_REQ)  index of the requester being written (debug)
reserve_valid  input  1  ICU reserves a destination stream
reserve_stream_id  input  NUM_STREAM_ID  stream being reserved
stream_busy  output  2**NUM_STREAM_ID  scoreboard; bit s=1 means a write to stream s is pending
reserve_error  output  1  one-cycle pulse: reserve hit an already-busy stream
unreserved_write  output  1  one-cycle pulse, aligned with srf_write_enable: committed write targeted a non-busy stream

Behaviour:
- Reset (async assert, clk-synchronous release):
  - srf_write_enable=0, srf_write_stream=0, srf_write_data all 0, srf_write_src=0.
  - stream_busy=0, reserve_error=0, unreserved_write=0.
  - Round-robin pointer rr_ptr=0.
  - Reset mid-transfer discards the registered write, and no write is emitted after release.
- Arbitration (combinational):
  - Scan requesters starting at rr_ptr, modulo NUM_REQ; the first with req_valid=1 wins.
  - req_ready is one-hot for the winner, or all zero if no req_valid.
  - The SRF port accepts one write every cycle, so there is no backpressure beyond losing arbitration.
  - A requester must hold valid, stream_id and data stable until it sees ready.
- Pointer update: on any handshake with winner w, rr_ptr <= (w+1) mod NUM_REQ. With no handshake, rr_ptr holds.
- Latency: a handshake in cycle N gives srf_write_enable=1 in cycle N+1 with that requester's stream/data/src. Back-to-back handshakes give back-to-back writes at full throughput. With no handshake, srf_write_enable=0 and the data/stream registers hold their last value.
- Scoreboard, per stream s, evaluated each cycle:
  - set_s = reserve_valid and reserve_stream_id==s.
  - clr_s = srf_write_enable and srf_write_stream==s (commit cycle).
  - Next busy_s = set_s ? 1 : (clr_s ? 0 : busy_s). When a reserve and a commit hit the same stream in the same cycle, the reserve wins and the bit stays 1 (new reservation).
- reserve_error: registered. It is 1 the cycle after a reserve whose stream had busy=1 and no same-cycle commit to it; the bit stays 1. A reserve coinciding with that stream's commit is not an error.
- unreserved_write: combinational from the registered output, = srf_write_enable and !stream_busy[srf_write_stream]. The write is still performed and the bit stays 0.
- Stream id width rule: ids are full range 0..2**NUM_STREAM_ID-1, with no wrap or masking. NUM_REQ that is not a power of 2 wraps the pointer explicitly, never via overflow.

Test Plan:
1. Reset then idle: hold rst=1 for 3 cycles, then release -> all outputs 0, stream_busy=0, and no write strobe for 10 idle cycles.
2. Single requester: reserve stream 7; next cycle req_valid=3'b010, stream 7, element e=e+1 -> req_ready=3'b010 the same cycle; next cycle srf_write_enable=1, stream 7, data[0]=1, data[19]=20, src=1, unreserved_write=0; stream_busy[7] goes 1 after reserve and 0 after commit.
3. Round-robin fairness: all three req_valid held for 6 cycles -> grants go 0,1,2,0,1,2, with srf_write_enable high on 6 consecutive cycles starting one cycle later.
4. Reserve collision: reserve stream 3 twice on consecutive cycles with no write -> reserve_error pulses once (the cycle after the second reserve) and stream_busy[3] stays 1.
5. Same-cycle reserve and commit to stream 5 -> stream_busy[5]=1 afterwards and reserve_error=0. A subsequent write to stream 5 clears it.
6. Async reset mid-operation: assert rst between clock edges while req_valid=3'b001 and a write is registered -> srf_write_enable drops immediately, stream_busy clears, and after release the first grant goes to requester 0.
